// File: rtl/instruction_decode_stage.sv
// instruction_decode_stage: registered instruction decoder with a 2-entry skid buffer
// between fetch and execute, flagging illegal encodings and counting delivered entries.
module instruction_decode_stage #(
    parameter int OPCODE_WIDTH = 6,
    parameter int ADDR_WIDTH = 8,
    parameter int REG_WIDTH = 3,
    parameter int VALUE_WIDTH = 16,
    parameter int NUM_OPCODES = 48,
    parameter int SIGN_EXTEND = 1,
    parameter int COUNT_WIDTH = 16,
    localparam int INSTRUCTION_WIDTH = OPCODE_WIDTH + 3 * ADDR_WIDTH + 6
) (
    input  logic                         clock,
    input  logic                         resetN,
    input  logic                         flush,
    input  logic                         inValid,
    output logic                         inReady,
    input  logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic                         outValid,
    input  logic                         outReady,
    output logic [OPCODE_WIDTH-1:0]      opCode,
    output logic [ADDR_WIDTH-1:0]        address1In,
    output logic [ADDR_WIDTH-1:0]        address2In,
    output logic [ADDR_WIDTH-1:0]        addressOut,
    output logic [1:0]                   address1Type,
    output logic [1:0]                   address2Type,
    output logic [1:0]                   outType,
    output logic [REG_WIDTH-1:0]         register1In,
    output logic [REG_WIDTH-1:0]         register2In,
    output logic [REG_WIDTH-1:0]         registerOut,
    output logic [VALUE_WIDTH-1:0]       instructionValue,
    output logic                         isImmediate,
    output logic                         illegal,
    output logic [COUNT_WIDTH-1:0]       decodeCount
);

    // Field order matches the instruction word layout, MSB first.
    typedef struct packed {
        logic [OPCODE_WIDTH-1:0] op_code;
        logic [ADDR_WIDTH-1:0]   addr1;
        logic [ADDR_WIDTH-1:0]   addr2;
        logic [ADDR_WIDTH-1:0]   addr_out;
        logic [1:0]              addr1_type;
        logic [1:0]              addr2_type;
        logic [1:0]              out_type;
    } raw_t;

    typedef struct packed {
        raw_t                   f;
        logic [VALUE_WIDTH-1:0] value;
        logic                   imm;
        logic                   illegal;
    } entry_t;

    raw_t                   raw;
    entry_t                 dec;
    entry_t                 main_entry;
    entry_t                 skid_entry;
    logic                   main_valid;
    logic                   skid_valid;
    logic [VALUE_WIDTH-1:0] ext;
    logic [COUNT_WIDTH-1:0] count;
    logic                   out_fire;

    assign raw = instruction;

    if (VALUE_WIDTH > ADDR_WIDTH) begin : g_ext
        assign ext = {{(VALUE_WIDTH - ADDR_WIDTH){(SIGN_EXTEND != 0) && raw.addr2[ADDR_WIDTH-1]}}, raw.addr2};
    end else begin : g_pass
        assign ext = raw.addr2;
    end

    always_comb begin
        dec.f       = raw;
        dec.value   = ext;
        dec.imm     = raw.addr2_type == 2'd3;
        dec.illegal = int'(raw.op_code) >= NUM_OPCODES || raw.out_type == 2'd3 || raw.addr1_type == 2'd3;
    end

    assign out_fire = main_valid && outReady;

    // Skid only fills when main is held by back-pressure; inReady is just !skid_valid.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_entry <= '0;
            skid_entry <= '0;
            count      <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            count      <= '0;
        end else begin
            if (out_fire)
                count <= count + COUNT_WIDTH'(1);
            if (skid_valid) begin
                if (out_fire) begin
                    main_entry <= skid_entry;
                    skid_valid <= 1'b0;
                end
            end else if (!main_valid || outReady) begin
                main_valid <= inValid;
                if (inValid)
                    main_entry <= dec;
            end else if (inValid) begin
                skid_entry <= dec;
                skid_valid <= 1'b1;
            end
        end
    end

    assign inReady          = !skid_valid;
    assign outValid         = main_valid;
    assign opCode           = main_entry.f.op_code;
    assign address1In       = main_entry.f.addr1;
    assign address2In       = main_entry.f.addr2;
    assign addressOut       = main_entry.f.addr_out;
    assign address1Type     = main_entry.f.addr1_type;
    assign address2Type     = main_entry.f.addr2_type;
    assign outType          = main_entry.f.out_type;
    assign register1In      = main_entry.f.addr1[REG_WIDTH-1:0];
    assign register2In      = main_entry.f.addr2[REG_WIDTH-1:0];
    assign registerOut      = main_entry.f.addr_out[REG_WIDTH-1:0];
    assign instructionValue = main_entry.value;
    assign isImmediate      = main_entry.imm;
    assign illegal          = main_entry.illegal;
    assign decodeCount      = count;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// tb_instruction_decode_stage: directed vector table plus hand-written handshake,
// flush, reset and counter-wrap sequences; a second instance covers zero-extend and a 4-bit counter.
module tb_instruction_decode_stage;

    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic        flush = 1'b0;
    logic        inValid = 1'b0;
    logic        outReady = 1'b0;
    logic [35:0] instruction = '0;

    logic        inReady, outValid, isImmediate, illegal;
    logic [5:0]  opCode;
    logic [7:0]  address1In, address2In, addressOut;
    logic [1:0]  address1Type, address2Type, outType;
    logic [2:0]  register1In, register2In, registerOut;
    logic [15:0] instructionValue, decodeCount;

    logic        z_inReady, z_outValid, z_isImmediate, z_illegal;
    logic [5:0]  z_opCode;
    logic [7:0]  z_address1In, z_address2In, z_addressOut;
    logic [1:0]  z_address1Type, z_address2Type, z_outType;
    logic [2:0]  z_register1In, z_register2In, z_registerOut;
    logic [15:0] z_instructionValue;
    logic [3:0]  z_decodeCount;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    instruction_decode_stage dut (
        .clock(clock), .resetN(resetN), .flush(flush),
        .inValid(inValid), .inReady(inReady), .instruction(instruction),
        .outValid(outValid), .outReady(outReady),
        .opCode(opCode), .address1In(address1In), .address2In(address2In), .addressOut(addressOut),
        .address1Type(address1Type), .address2Type(address2Type), .outType(outType),
        .register1In(register1In), .register2In(register2In), .registerOut(registerOut),
        .instructionValue(instructionValue), .isImmediate(isImmediate), .illegal(illegal),
        .decodeCount(decodeCount)
    );

    instruction_decode_stage #(.SIGN_EXTEND(0), .COUNT_WIDTH(4)) dut_z (
        .clock(clock), .resetN(resetN), .flush(flush),
        .inValid(inValid), .inReady(z_inReady), .instruction(instruction),
        .outValid(z_outValid), .outReady(outReady),
        .opCode(z_opCode), .address1In(z_address1In), .address2In(z_address2In), .addressOut(z_addressOut),
        .address1Type(z_address1Type), .address2Type(z_address2Type), .outType(z_outType),
        .register1In(z_register1In), .register2In(z_register2In), .registerOut(z_registerOut),
        .instructionValue(z_instructionValue), .isImmediate(z_isImmediate), .illegal(z_illegal),
        .decodeCount(z_decodeCount)
    );

    typedef struct {
        logic [35:0] instr;
        logic [5:0]  op;
        logic [7:0]  a1, a2, ao;
        logic [2:0]  r1, r2, ro;
        logic [1:0]  t1, t2, to;
        logic [15:0] se, ze;
        logic        imm, ill;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_vec(input vec_t v);
        check("outValid", outValid, 1);
        check("opCode", opCode, v.op);
        check("address1In", address1In, v.a1);
        check("address2In", address2In, v.a2);
        check("addressOut", addressOut, v.ao);
        check("register1In", register1In, v.r1);
        check("register2In", register2In, v.r2);
        check("registerOut", registerOut, v.ro);
        check("address1Type", address1Type, v.t1);
        check("address2Type", address2Type, v.t2);
        check("outType", outType, v.to);
        check("value_sext", instructionValue, v.se);
        check("value_zext", z_instructionValue, v.ze);
        check("isImmediate", isImmediate, v.imm);
        check("illegal", illegal, v.ill);
        check("illegal_z", z_illegal, v.ill);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{36'h144BC01CC, 6'd5, 8'h12, 8'hF0, 8'h07, 3'd2, 3'd0, 3'd7, 2'd0, 2'd3, 2'd0, 16'hFFF0, 16'h00F0, 1'b1, 1'b0};
        vecs[1] = '{{6'd48, 8'h01, 8'h02, 8'h03, 6'b00_00_00}, 6'd48, 8'h01, 8'h02, 8'h03, 3'd1, 3'd2, 3'd3, 2'd0, 2'd0, 2'd0, 16'h0002, 16'h0002, 1'b0, 1'b1};
        vecs[2] = '{{6'd47, 8'hFF, 8'h7F, 8'h08, 6'b00_01_11}, 6'd47, 8'hFF, 8'h7F, 8'h08, 3'd7, 3'd7, 3'd0, 2'd0, 2'd1, 2'd3, 16'h007F, 16'h007F, 1'b0, 1'b1};
        vecs[3] = '{{6'd47, 8'hAA, 8'h80, 8'h55, 6'b00_00_00}, 6'd47, 8'hAA, 8'h80, 8'h55, 3'd2, 3'd0, 3'd5, 2'd0, 2'd0, 2'd0, 16'hFF80, 16'h0080, 1'b0, 1'b0};
        vecs[4] = '{{6'd63, 8'h00, 8'h00, 8'h00, 6'b10_10_10}, 6'd63, 8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 3'd0, 2'd2, 2'd2, 2'd2, 16'h0000, 16'h0000, 1'b0, 1'b1};
        vecs[5] = '{{6'd0, 8'h3C, 8'hC3, 8'hE9, 6'b11_01_10}, 6'd0, 8'h3C, 8'hC3, 8'hE9, 3'd4, 3'd3, 3'd1, 2'd3, 2'd1, 2'd2, 16'hFFC3, 16'h00C3, 1'b0, 1'b1};
        vecs[6] = '{{6'd1, 8'h0F, 8'hFF, 8'hF8, 6'b01_11_01}, 6'd1, 8'h0F, 8'hFF, 8'hF8, 3'd7, 3'd7, 3'd0, 2'd1, 2'd3, 2'd1, 16'hFFFF, 16'h00FF, 1'b1, 1'b0};

        step();
        step();
        check("reset outValid", outValid, 0);
        check("reset inReady", inReady, 1);
        check("reset decodeCount", decodeCount, 0);
        check("reset opCode", opCode, 0);
        check("reset instructionValue", instructionValue, 0);
        resetN = 1'b1;

        outReady = 1'b1;
        foreach (vecs[i]) begin
            instruction = vecs[i].instr;
            inValid = 1'b1;
            step();
            inValid = 1'b0;
            check_vec(vecs[i]);
            step();
            check("drained outValid", outValid, 0);
        end
        check("table decodeCount", decodeCount, 7);
        check("table decodeCount_z", z_decodeCount, 7);

        // Back-pressure: A to main, B to skid, C held until consumer drains.
        outReady = 1'b0;
        instruction = {6'd10, 8'hA0, 8'h00, 8'h00, 6'b0};
        inValid = 1'b1;
        step();
        check("bp A accepted inReady", inReady, 1);
        instruction = {6'd11, 8'hB0, 8'h00, 8'h00, 6'b0};
        step();
        check("bp skid full inReady", inReady, 0);
        check("bp A on output", opCode, 10);
        instruction = {6'd12, 8'hC0, 8'h00, 8'h00, 6'b0};
        step();
        check("bp C held inReady", inReady, 0);
        check("bp A stable", address1In, 8'hA0);
        outReady = 1'b1;
        step();
        check("bp B outValid", outValid, 1);
        check("bp B second", opCode, 11);
        check("bp inReady back", inReady, 1);
        step();
        inValid = 1'b0;
        check("bp C outValid", outValid, 1);
        check("bp C third", opCode, 12);
        step();
        check("bp drained", outValid, 0);
        check("bp decodeCount", decodeCount, 10);

        // Flush with both entries occupied; same-cycle handshakes must be ignored.
        outReady = 1'b0;
        instruction = {6'd20, 8'h01, 8'h00, 8'h00, 6'b0};
        inValid = 1'b1;
        step();
        instruction = {6'd21, 8'h02, 8'h00, 8'h00, 6'b0};
        step();
        check("flush pre skid full", inReady, 0);
        instruction = {6'd22, 8'h03, 8'h00, 8'h00, 6'b0};
        outReady = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        inValid = 1'b0;
        check("flush outValid", outValid, 0);
        check("flush decodeCount", decodeCount, 0);
        check("flush decodeCount_z", z_decodeCount, 0);
        check("flush inReady", inReady, 1);
        step();
        check("flush no accept", outValid, 0);
        check("flush count hold", decodeCount, 0);

        for (int i = 0; i < 100; i++) begin
            instruction = {6'(i % 48), 8'(i), 8'h00, 8'h00, 6'b0};
            inValid = 1'b1;
            step();
            check("stream outValid", outValid, 1);
            check("stream order", address1In, 8'(i));
        end
        inValid = 1'b0;
        step();
        check("stream decodeCount", decodeCount, 100);
        check("stream decodeCount_z", z_decodeCount, 4);
        check("stream drained", outValid, 0);

        flush = 1'b1;
        step();
        flush = 1'b0;
        inValid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            instruction = {6'd3, 8'(i), 8'h00, 8'h00, 6'b0};
            step();
        end
        inValid = 1'b0;
        step();
        check("wrap decodeCount_z", z_decodeCount, 1);
        check("wrap decodeCount", decodeCount, 17);

        // Asynchronous reset in the middle of a cycle with an entry held.
        outReady = 1'b0;
        instruction = {6'd33, 8'h44, 8'h00, 8'h00, 6'b0};
        inValid = 1'b1;
        step();
        inValid = 1'b0;
        check("areset pre outValid", outValid, 1);
        #2;
        resetN = 1'b0;
        #1;
        check("areset outValid", outValid, 0);
        check("areset opCode", opCode, 0);
        check("areset inReady", inReady, 1);
        check("areset decodeCount", decodeCount, 0);
        step();
        resetN = 1'b1;
        outReady = 1'b1;
        step();
        check("areset no stale", outValid, 0);
        instruction = {6'd9, 8'h55, 8'h00, 8'h00, 6'b0};
        inValid = 1'b1;
        step();
        inValid = 1'b0;
        check("post reset outValid", outValid, 1);
        check("post reset opCode", opCode, 9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
